// File: rtl/traffic_light_sequencer.sv
// Two-road traffic light controller: main road rests in green until a side request
// arrives, then runs a yellow / all-red / side-green / side-yellow / all-red cycle.
module traffic_light_sequencer #(
    parameter int GREEN_TICKS  = 10,
    parameter int YELLOW_TICKS = 3,
    parameter int ALLRED_TICKS = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic       side_req,
    output logic       timer_reset,
    output logic [2:0] main_light,
    output logic [2:0] side_light,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        MAIN_GREEN  = 3'd0,
        MAIN_YELLOW = 3'd1,
        ALLRED_1    = 3'd2,
        SIDE_GREEN  = 3'd3,
        SIDE_YELLOW = 3'd4,
        ALLRED_2    = 3'd5
    } state_t;

    localparam logic [7:0] GREEN_LAST  = 8'(GREEN_TICKS - 1);
    localparam logic [7:0] YELLOW_LAST = 8'(YELLOW_TICKS - 1);
    localparam logic [7:0] ALLRED_LAST = 8'(ALLRED_TICKS - 1);

    state_t     cur_state;
    state_t     next_state;
    logic [7:0] tick_count;
    logic [7:0] dwell_last;
    logic       req_pending;
    logic       tick;
    logic       at_limit;
    logic       advance;

    // Light encoding is {main, side}, each {red, yellow, green}.
    function automatic logic [5:0] lights_for(input state_t s);
        logic [5:0] l;
        l = 6'b100_100;
        case (s)
            MAIN_GREEN:  l = 6'b001_100;
            MAIN_YELLOW: l = 6'b010_100;
            SIDE_GREEN:  l = 6'b100_001;
            SIDE_YELLOW: l = 6'b100_010;
            default:     l = 6'b100_100;
        endcase
        return l;
    endfunction

    assign tick     = enable & ~timer_reset;
    assign at_limit = (tick_count == dwell_last);
    assign state    = cur_state;

    always_comb begin
        dwell_last = ALLRED_LAST;
        case (cur_state)
            MAIN_GREEN, SIDE_GREEN:   dwell_last = GREEN_LAST;
            MAIN_YELLOW, SIDE_YELLOW: dwell_last = YELLOW_LAST;
            default:                  dwell_last = ALLRED_LAST;
        endcase
    end

    // Main green is the resting state: it only leaves once the minimum dwell is served
    // and a request is already latched.
    always_comb begin
        next_state = cur_state;
        advance    = 1'b0;
        case (cur_state)
            MAIN_GREEN: begin
                if (tick && at_limit && req_pending) begin
                    next_state = MAIN_YELLOW;
                    advance    = 1'b1;
                end
            end
            MAIN_YELLOW: begin
                if (tick && at_limit) begin
                    next_state = ALLRED_1;
                    advance    = 1'b1;
                end
            end
            ALLRED_1: begin
                if (tick && at_limit) begin
                    next_state = SIDE_GREEN;
                    advance    = 1'b1;
                end
            end
            SIDE_GREEN: begin
                if (tick && at_limit) begin
                    next_state = SIDE_YELLOW;
                    advance    = 1'b1;
                end
            end
            SIDE_YELLOW: begin
                if (tick && at_limit) begin
                    next_state = ALLRED_2;
                    advance    = 1'b1;
                end
            end
            ALLRED_2: begin
                if (tick && at_limit) begin
                    next_state = MAIN_GREEN;
                    advance    = 1'b1;
                end
            end
            default: begin
                next_state = ALLRED_2;
                advance    = 1'b1;
            end
        endcase
    end

    // Lights are loaded from the next state on the same edge the state moves, so they
    // never lag the state code; the counter saturates at the dwell limit.
    always_ff @(posedge clock) begin
        if (reset) begin
            cur_state   <= ALLRED_2;
            tick_count  <= 8'd0;
            timer_reset <= 1'b1;
            req_pending <= 1'b0;
            main_light  <= 3'b100;
            side_light  <= 3'b100;
        end else begin
            if (side_req)
                req_pending <= 1'b1;
            else if (advance && next_state == SIDE_GREEN)
                req_pending <= 1'b0;

            timer_reset <= advance;

            if (advance) begin
                cur_state                <= next_state;
                tick_count               <= 8'd0;
                {main_light, side_light} <= lights_for(next_state);
            end else if (tick && !at_limit) begin
                tick_count <= tick_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_traffic_light_sequencer.sv
// Scoreboard bench: each scenario queues the state sequence it expects with the number
// of enable ticks spent in the state being left; a negedge monitor pops and compares.
module tb_traffic_light_sequencer;

    localparam logic [2:0] S_MG = 3'd0;
    localparam logic [2:0] S_MY = 3'd1;
    localparam logic [2:0] S_A1 = 3'd2;
    localparam logic [2:0] S_SG = 3'd3;
    localparam logic [2:0] S_SY = 3'd4;
    localparam logic [2:0] S_A2 = 3'd5;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic       side_req = 1'b0;
    logic       timer_reset;
    logic [2:0] main_light;
    logic [2:0] side_light;
    logic [2:0] state;

    typedef struct {
        logic [2:0] st;
        int         ticks;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   ticks = 0;
    int   cyc = 0;
    bit   primed = 0;
    logic [2:0] prev_state;
    logic prev_exp_tr = 1'b1;

    traffic_light_sequencer #(
        .GREEN_TICKS (4),
        .YELLOW_TICKS(2),
        .ALLRED_TICKS(1)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .side_req   (side_req),
        .timer_reset(timer_reset),
        .main_light (main_light),
        .side_light (side_light),
        .state      (state)
    );

    always #5 clock = ~clock;

    function automatic logic [5:0] exp_lights(input logic [2:0] s);
        case (s)
            3'd0:    return 6'b001_100;
            3'd1:    return 6'b010_100;
            3'd3:    return 6'b100_001;
            3'd4:    return 6'b100_010;
            default: return 6'b100_100;
        endcase
    endfunction

    // Per-cycle monitor: light table, exclusivity, timer_reset pulse and dwell scoreboard.
    always @(negedge clock) begin
        logic exp_tr;
        logic eff;
        exp_t e;
        if (primed) begin
            tests++;
            if ({main_light, side_light} !== exp_lights(state)) begin
                fails++;
                $display("[TB] FAIL lights: state=%0d got main=%b side=%b want %b", state, main_light, side_light, exp_lights(state));
            end
            tests++;
            if (!$onehot(main_light) || !$onehot(side_light) || (!main_light[2] && !side_light[2])) begin
                fails++;
                $display("[TB] FAIL exclusive: got main=%b side=%b want one-hot with a red road", main_light, side_light);
            end
            exp_tr = reset || (state !== prev_state);
            tests++;
            if (timer_reset !== exp_tr) begin
                fails++;
                $display("[TB] FAIL timer_reset: got %b want %b (state %0d->%0d)", timer_reset, exp_tr, prev_state, state);
            end
            eff = enable && !prev_exp_tr;
            if (reset) begin
                ticks = 0;
            end else if (state !== prev_state) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("[TB] FAIL unexpected_transition: got %0d->%0d want no change", prev_state, state);
                end else begin
                    e = exp_q.pop_front();
                    if (state !== e.st || ticks + int'(eff) != e.ticks) begin
                        fails++;
                        $display("[TB] FAIL transition: got state %0d after %0d ticks want state %0d after %0d ticks", state, ticks + int'(eff), e.st, e.ticks);
                    end
                end
                ticks = 0;
            end else begin
                ticks += int'(eff);
            end
            prev_exp_tr = exp_tr;
        end
        primed     = 1;
        prev_state = state;
        cyc++;
        enable = (cyc % 5 == 0);
    end

    task automatic push_exp(input logic [2:0] st, input int t);
        exp_t e;
        e.st    = st;
        e.ticks = t;
        exp_q.push_back(e);
    endtask

    task automatic push_rest_of_cycle();
        push_exp(S_A1, 2);
        push_exp(S_SG, 1);
        push_exp(S_SY, 4);
        push_exp(S_A2, 2);
        push_exp(S_MG, 1);
    endtask

    task automatic wait_drain(input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clock); #1;
            if (exp_q.size() == 0) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic wait_state(input logic [2:0] st, input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clock); #1;
            if (state === st) begin
                ok = 1;
                break;
            end
        end
    endtask

    // Returns once the main green has served min_ticks and the next edge is not a tick.
    task automatic wait_quiet_ticks(input int min_ticks, output int k);
        for (int i = 0; i < 500; i++) begin
            @(negedge clock); #1;
            if (ticks >= min_ticks && !enable) break;
        end
        k = ticks;
    endtask

    task automatic pulse_req();
        side_req = 1'b1;
        @(negedge clock); #1;
        side_req = 1'b0;
    endtask

    task automatic restart(input int n);
        bit ok;
        reset = 1'b1;
        repeat (n) begin
            @(negedge clock); #1;
        end
        exp_q.delete();
        push_exp(S_MG, 1);
        reset = 1'b0;
        wait_drain(60, ok);
        tests++;
        if (!ok) begin
            fails++;
            $display("[TB] FAIL restart_timeout: got queue size %0d want 0", exp_q.size());
        end
    endtask

    task automatic check_hold(input string name, input int n);
        repeat (n) begin
            @(negedge clock); #1;
        end
        tests++;
        if (state !== S_MG || exp_q.size() != 0) begin
            fails++;
            $display("[TB] FAIL %s: got state %0d queue %0d want state 0 queue 0", name, state, exp_q.size());
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) begin
            @(negedge clock); #1;
        end
        tests++;
        if (state !== S_A2) begin
            fails++;
            $display("[TB] FAIL reset_state: got %0d want 5", state);
        end
        tests++;
        if (main_light !== 3'b100 || side_light !== 3'b100) begin
            fails++;
            $display("[TB] FAIL reset_lights: got %b/%b want 100/100", main_light, side_light);
        end
        tests++;
        if (timer_reset !== 1'b1) begin
            fails++;
            $display("[TB] FAIL reset_timer: got %b want 1", timer_reset);
        end
        restart(1);
        check_hold("reset_hold", 60);
    endtask

    task automatic test_side_cycle();
        int k;
        bit ok;
        restart(2);
        wait_quiet_ticks(1, k);
        push_exp(S_MY, 4);
        push_rest_of_cycle();
        pulse_req();
        wait_drain(300, ok);
        tests++;
        if (!ok) begin
            fails++;
            $display("[TB] FAIL side_cycle_timeout: got queue size %0d want 0", exp_q.size());
        end
        check_hold("side_cycle_hold", 60);
    endtask

    task automatic test_late_request();
        int k;
        bit ok;
        wait_quiet_ticks(6, k);
        push_exp(S_MY, k + 1);
        push_rest_of_cycle();
        pulse_req();
        wait_drain(300, ok);
        tests++;
        if (!ok) begin
            fails++;
            $display("[TB] FAIL late_request_timeout: got queue size %0d want 0", exp_q.size());
        end
    endtask

    task automatic test_held_request();
        int k;
        bit ok;
        wait_quiet_ticks(4, k);
        push_exp(S_MY, k + 1);
        push_rest_of_cycle();
        push_exp(S_MY, 4);
        push_rest_of_cycle();
        side_req = 1'b1;
        wait_state(S_SY, 300, ok);
        side_req = 1'b0;
        tests++;
        if (!ok) begin
            fails++;
            $display("[TB] FAIL held_request_side_yellow: got state %0d want 4", state);
        end
        wait_drain(400, ok);
        tests++;
        if (!ok) begin
            fails++;
            $display("[TB] FAIL held_request_timeout: got queue size %0d want 0", exp_q.size());
        end
        check_hold("held_request_hold", 60);
    endtask

    task automatic test_reset_mid();
        int k;
        bit ok;
        wait_quiet_ticks(4, k);
        push_exp(S_MY, k + 1);
        push_exp(S_A1, 2);
        push_exp(S_SG, 1);
        push_exp(S_SY, 4);
        pulse_req();
        wait_state(S_SY, 300, ok);
        tests++;
        if (!ok) begin
            fails++;
            $display("[TB] FAIL reset_mid_reach: got state %0d want 4", state);
        end
        reset = 1'b1;
        @(negedge clock); #1;
        tests++;
        if (state !== S_A2 || main_light !== 3'b100 || side_light !== 3'b100 || timer_reset !== 1'b1) begin
            fails++;
            $display("[TB] FAIL reset_mid: got state %0d lights %b/%b tr %b want 5 100/100 1", state, main_light, side_light, timer_reset);
        end
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("[TB] FAIL reset_mid_queue: got %0d pending want 0", exp_q.size());
        end
        push_exp(S_MG, 1);
        reset = 1'b0;
        wait_drain(60, ok);
        tests++;
        if (!ok) begin
            fails++;
            $display("[TB] FAIL reset_mid_timeout: got queue size %0d want 0", exp_q.size());
        end
        check_hold("reset_mid_req_cleared", 60);
    endtask

    initial begin
        test_reset();
        test_side_cycle();
        test_late_request();
        test_held_request();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
